led_fade: RTL
=============

# led_fade

Soft-edge LED driver placed directly downstream of the blink generator on the Cyclone IV board. It consumes the 1-bit blink level and drives the physical LED pin with PWM. When the input changes, brightness ramps linearly up or down instead of switching hard. It runs in the 50 MHz board clock domain and needs no CPU or bus.

## Interface
- PWM_BITS, 8: PWM and brightness resolution; MAX = 2^PWM_BITS-1; legal range 2..16
- RAMP_DIV, 19_608: clocks per brightness step; a full ramp is MAX*RAMP_DIV clocks (≈100 ms at 50 MHz); must be ≥1
- clock  input  1  system clock, single domain
- reset  input  1  synchronous, active-high
- led_in  input  1  target level from the blink stage: 1 = on, 0 = off
- pwm_out  output  1  registered PWM drive to the LED pin
- level  output  PWM_BITS  current brightness, 0..MAX
- busy  output  1  high while a ramp is in progress

## Operation
- led_in is registered into led_q; all decisions use led_q.
- State machine:
  - OFF: level = 0. If led_q=1, go to UP.
  - UP: on each ramp tick, level++. On reaching MAX, go to ON.
  - ON: level = MAX. If led_q=0, go to DOWN.
  - DOWN: on each ramp tick, level--. On reaching 0, go to OFF.
- Reversal mid-ramp: if led_q=0 while in UP, go to DOWN in the same cycle. If led_q=1 while in DOWN, go to UP. level continues from its current value with no jump.
- A reversal and a tick in the same cycle: the transition wins and level is unchanged that cycle.
- Ramp prescaler: counts 0..RAMP_DIV-1 only while in UP or DOWN.
  - It clears on every state transition.
  - A tick occurs when the count equals RAMP_DIV-1, and the count then wraps to 0.
- level saturates at 0 and MAX; it never wraps.
- busy = (state is UP or DOWN).
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps MAX→0.
  - duty is latched from the brightness map only when pwm_cnt = MAX, so there are no mid-period glitches.
  - pwm_out <= 1 if duty = MAX; otherwise pwm_out <= (pwm_cnt < duty).
  - Result: duty 0 is fully dark and duty MAX is fully lit.
- Reset, including mid-ramp: state OFF, level 0, led_q 0, duty 0, pwm_cnt 0, prescaler 0, pwm_out 0, busy 0. Ramping restarts from 0 after reset.

## Timing
- Edge on led_in at cycle n:
  - led_q changes at n+1.
  - State and busy change at n+2.
- First level step occurs RAMP_DIV cycles after entering UP/DOWN. Full ramp 0→MAX takes MAX*RAMP_DIV cycles.
- A level change affects pwm_out at the next PWM period boundary, i.e. within 2^PWM_BITS+1 cycles.
- PWM period is 2^PWM_BITS clocks. High time per period equals duty, or the whole period when duty = MAX.
- No handshake: led_in may change on any cycle. Pulses shorter than one clock are not supported.

## Configuration
- LED_FADE_GAMMA_EN defined: the brightness map is quadratic.
  - duty = (level*level) >> PWM_BITS.
  - level = MAX forces duty = MAX.
  - Uses a 2*PWM_BITS-bit product.
- Not defined: duty = level (linear), and no multiplier is inferred.
- The level output is unaffected either way.

## Structure
- Package led_fade_pkg holds:
  - state enum: OFF, UP, ON, DOWN
  - width helper for the RAMP_DIV counter (clog2)
  - the shared brightness-map function (with and without gamma)
- Sub-module pwm_gen (parameter PWM_BITS; ports clock, reset, duty_in, pwm_out) owns pwm_cnt, the duty latch and the compare.
- led_fade holds the input register, FSM, prescaler and level register.

## Test plan
All scenarios use PWM_BITS=4 (MAX=15) and RAMP_DIV=3 unless stated.
- Reset then idle, led_in=0 for 100 cycles -> level=0, pwm_out=0, busy=0 throughout.
- led_in 0→1 at cycle 10 -> busy=1 at cycle 12, level=1 at cycle 15, level=15 with busy=0 at cycle 57, pwm_out constantly 1 from the next period onward.
- From ON, led_in→0, then led_in→1 when level reaches 7 -> level never goes below 7, it returns to 15 after a further 8*3 cycles, and there is no level jump.
- Hold level=8 with gamma off -> exactly 8 high cycles per 16-cycle period. Same with LED_FADE_GAMMA_EN defined -> 4 high cycles.
- reset asserted for 1 cycle mid-UP at level 9 -> next cycle level=0, state OFF, pwm_out=0. With led_in still 1, the ramp restarts from 0.
- Edge case RAMP_DIV=1, PWM_BITS=2 -> level steps every cycle in a ramp, and the full ramp takes 3 cycles.

Source files
------------

// File: rtl/led_fade_pkg.sv
// rtl/led_fade_pkg.sv - shared types and helpers for the LED fader.
// LED_FADE_GAMMA_EN selects the quadratic brightness map; undefined gives a linear map.
package led_fade_pkg;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_UP,
      ST_ON,
      ST_DOWN
   } state_e;

   localparam int unsigned MAP_W = 16;

   function automatic int unsigned cnt_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

   // Callers truncate the result to their own PWM width; bits is that width.
   function automatic logic [MAP_W-1:0] bright_map(input logic [MAP_W-1:0] lvl,
                                                   input int unsigned bits);
      logic [MAP_W-1:0] max_v;
`ifdef LED_FADE_GAMMA_EN
      logic [2*MAP_W-1:0] prod;
`endif
      max_v = MAP_W'((32'd1 << bits) - 32'd1);
`ifdef LED_FADE_GAMMA_EN
      prod = {{MAP_W{1'b0}}, lvl} * {{MAP_W{1'b0}}, lvl};
      if (lvl == max_v)
         return max_v;
      return MAP_W'(prod >> bits);
`else
      return lvl & max_v;
`endif
   endfunction

endpackage

// File: rtl/led_fade_pwm_gen.sv
// rtl/led_fade_pwm_gen.sv - free-running PWM with duty latched at period end.
module pwm_gen
   import led_fade_pkg::*;
#(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PWM_BITS-1:0] duty_in,
   output logic                pwm_out
);

   localparam logic [PWM_BITS-1:0] MAX = '1;

   logic [PWM_BITS-1:0] cnt_q;
   logic [PWM_BITS-1:0] duty_q;
   logic                pwm_q;

   // Duty only updates at the period boundary so a period is never split.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q  <= '0;
         duty_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == MAX)
            duty_q <= duty_in;
         pwm_q <= (duty_q == MAX) || (cnt_q < duty_q);
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: rtl/led_fade.sv
// rtl/led_fade.sv - soft-edge LED driver: ramps brightness on led_in edges, drives PWM.
// Brightness map is set by LED_FADE_GAMMA_EN (see led_fade_pkg).
module led_fade
   import led_fade_pkg::*;
#(
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned RAMP_DIV = 19_608
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                led_in,
   output logic                pwm_out,
   output logic [PWM_BITS-1:0] level,
   output logic                busy
);

   localparam int unsigned         CNT_W    = cnt_width(RAMP_DIV);
   localparam logic [PWM_BITS-1:0] MAX      = '1;
   localparam logic [CNT_W-1:0]    DIV_LAST = CNT_W'(RAMP_DIV - 1);

   state_e              state_q, state_d;
   logic [PWM_BITS-1:0] level_q, level_d;
   logic [CNT_W-1:0]    pre_q, pre_d;
   logic                led_q;
   logic                tick;
   logic [PWM_BITS-1:0] duty;

   assign busy = (state_q == ST_UP) || (state_q == ST_DOWN);
   assign tick = (pre_q == DIV_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_OFF;
         level_q <= '0;
         pre_q   <= '0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         pre_q   <= pre_d;
         led_q   <= led_in;
      end
   end

   // A reversal takes priority over a tick so the level never jumps.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      unique case (state_q)
         ST_OFF: if (led_q) state_d = ST_UP;
         ST_UP: begin
            if (!led_q)
               state_d = ST_DOWN;
            else if (level_q == MAX)
               state_d = ST_ON;
            else if (tick) begin
               level_d = level_q + 1'b1;
               if (level_q == MAX - 1'b1)
                  state_d = ST_ON;
            end
         end
         ST_ON: if (!led_q) state_d = ST_DOWN;
         ST_DOWN: begin
            if (led_q)
               state_d = ST_UP;
            else if (level_q == '0)
               state_d = ST_OFF;
            else if (tick) begin
               level_d = level_q - 1'b1;
               if (level_q == {{(PWM_BITS-1){1'b0}}, 1'b1})
                  state_d = ST_OFF;
            end
         end
      endcase

      pre_d = '0;
      if (busy && (state_d == state_q) && !tick)
         pre_d = pre_q + 1'b1;
   end

   assign duty  = PWM_BITS'(bright_map(MAP_W'(level_q), PWM_BITS));
   assign level = level_q;

   pwm_gen #(
      .PWM_BITS(PWM_BITS)
   ) u_pwm (
      .clock   (clock),
      .reset   (reset),
      .duty_in (duty),
      .pwm_out (pwm_out)
   );

endmodule
